// File: rtl/fp_pkg.sv
// Shared types and constants for the FP round/pack stage.
// Enumerations for operand class and rounding mode, plus the S1 payload layout.
package fp_pkg;

    localparam int FP_EXP_W   = 10;
    localparam int FP_FRAC_W  = 23;
    localparam int FP_BIAS    = 127;
    localparam int FP_EXP_MAX = 255;
    localparam logic [31:0] FP_QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        ZERO   = 2'b01,
        INF    = 2'b10,
        NAN    = 2'b11
    } fp_class_e;

    typedef enum logic [1:0] {
        RNE = 2'b00,
        RTZ = 2'b01,
        RUP = 2'b10,
        RDN = 2'b11
    } rnd_mode_e;

    // Exponent carries one extra sign bit so the rounding carry never wraps.
    typedef struct packed {
        logic                   sign;
        fp_class_e              cls;
        logic [FP_EXP_W:0]      exp;
        logic [FP_FRAC_W-1:0]   frac;
        logic                   inexact;
        rnd_mode_e              mode;
    } s1_payload_t;

endpackage

// File: rtl/fp_rounder.sv
// Combinational rounding of a normalised mantissa: increment decision,
// carry into the exponent and the inexact indication.
module fp_rounder
    import fp_pkg::*;
#(
    parameter int EXP_W = 10,
    parameter int MAN_W = 26
) (
    input  logic                 sign,
    input  logic [1:0]           mode,
    input  logic [EXP_W-1:0]     exp_in,
    input  logic [MAN_W-1:0]     man_in,
    output logic [FP_FRAC_W-1:0] frac_out,
    output logic [EXP_W:0]       exp_out,
    output logic                 inexact
);

    logic                 lsb;
    logic                 g;
    logic                 r;
    logic                 s;
    logic                 any_lost;
    logic                 inc;
    logic [FP_FRAC_W:0]   frac24;

    always_comb begin
        lsb      = man_in[3];
        g        = man_in[2];
        r        = man_in[1];
        s        = man_in[0];
        any_lost = g | r | s;
        inc      = 1'b0;
        case (rnd_mode_e'(mode))
            RNE:     inc = g & (r | s | lsb);
            RTZ:     inc = 1'b0;
            RUP:     inc = ~sign & any_lost;
            RDN:     inc = sign & any_lost;
            default: inc = 1'b0;
        endcase

        // A carry out of the fraction leaves it all-zero and bumps the exponent.
        frac24   = {1'b0, man_in[MAN_W-1:3]} + {{FP_FRAC_W{1'b0}}, inc};
        frac_out = frac24[FP_FRAC_W-1:0];
        exp_out  = {exp_in[EXP_W-1], exp_in} + {{EXP_W{1'b0}}, frac24[FP_FRAC_W]};
        inexact  = any_lost;
    end

endmodule

// File: rtl/fp_round_pack.sv
// Final FP mul/div stage: S1 rounds, S2 packs into IEEE single with flags.
// Optional macro FP_ROUND_MODES_EN adds the rnd_mode port (RNE/RTZ/RUP/RDN).
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W = 10,
    parameter int MAN_W = 26
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign_in,
`ifdef FP_ROUND_MODES_EN
    input  logic [1:0]       rnd_mode,
`endif
    input  logic [1:0]       class_in,
    input  logic [EXP_W-1:0] exponent_in,
    input  logic [MAN_W-1:0] mantissa_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic             flag_overflow,
    output logic             flag_underflow,
    output logic             flag_inexact
);

    // Handshake: a stage transfers on a rising edge when its valid and the
    // downstream ready are both high; ready never depends on in_valid, and a
    // full stage keeps its contents unchanged until it is drained.

    logic             s1_valid;
    logic             s2_valid;
    logic             s1_adv;
    logic             s2_adv;
    logic [1:0]       mode_in;
    s1_payload_t      s1_d;
    s1_payload_t      s1_q;

    logic [FP_FRAC_W-1:0] rnd_frac;
    logic [EXP_W:0]       rnd_exp;
    logic                 rnd_inexact;

    logic [31:0]      res_d;
    logic             ovf_d;
    logic             unf_d;
    logic             inx_d;
    logic             exp_big;
    logic             exp_small;
    logic             sat_max;

    assign s2_adv    = ~s2_valid | out_ready;
    assign s1_adv    = ~s1_valid | s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

`ifdef FP_ROUND_MODES_EN
    assign mode_in = rnd_mode;
`else
    assign mode_in = RNE;
`endif

    fp_rounder #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_rounder (
        .sign     (sign_in),
        .mode     (mode_in),
        .exp_in   (exponent_in),
        .man_in   (mantissa_in),
        .frac_out (rnd_frac),
        .exp_out  (rnd_exp),
        .inexact  (rnd_inexact)
    );

    always_comb begin
        s1_d         = '0;
        s1_d.sign    = sign_in;
        s1_d.cls     = fp_class_e'(class_in);
        s1_d.exp     = rnd_exp;
        s1_d.frac    = rnd_frac;
        s1_d.inexact = rnd_inexact;
        s1_d.mode    = rnd_mode_e'(mode_in);
    end

    // Pack from the S1 register; the exponent is signed, so the top bit marks <= -1.
    always_comb begin
        res_d     = '0;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        inx_d     = 1'b0;
        exp_big   = ~s1_q.exp[FP_EXP_W] &
                    (s1_q.exp[FP_EXP_W-1:0] >= FP_EXP_W'(FP_EXP_MAX));
        exp_small = s1_q.exp[FP_EXP_W] | (s1_q.exp == '0);
        sat_max   = (s1_q.mode == RTZ) |
                    ((s1_q.mode == RUP) & s1_q.sign) |
                    ((s1_q.mode == RDN) & ~s1_q.sign);
        case (s1_q.cls)
            NAN:  res_d = FP_QNAN;
            INF:  res_d = {s1_q.sign, 8'hFF, 23'h0};
            ZERO: res_d = {s1_q.sign, 31'h0};
            default: begin
                if (exp_big) begin
                    ovf_d = 1'b1;
                    inx_d = 1'b1;
                    res_d = sat_max ? {s1_q.sign, 8'hFE, 23'h7FFFFF}
                                    : {s1_q.sign, 8'hFF, 23'h0};
                end else if (exp_small) begin
                    unf_d = 1'b1;
                    inx_d = 1'b1;
                    res_d = {s1_q.sign, 31'h0};
                end else begin
                    inx_d = s1_q.inexact;
                    res_d = {s1_q.sign, s1_q.exp[7:0], s1_q.frac};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s1_valid       <= 1'b0;
            s1_q           <= '0;
            s2_valid       <= 1'b0;
            result         <= 32'h0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (in_valid && s1_adv) begin
                s1_q <= s1_d;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s1_valid && s2_adv) begin
                result         <= res_d;
                flag_overflow  <= ovf_d;
                flag_underflow <= unf_d;
                flag_inexact   <= inx_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_round_pack.sv
// Directed bench for fp_round_pack: vector table plus backpressure and
// mid-stream reset sequences.
module tb_fp_round_pack;

    logic        clk;
    logic        arst_n;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [1:0]  class_in;
    logic [9:0]  exponent_in;
    logic [25:0] mantissa_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_overflow;
    logic        flag_underflow;
    logic        flag_inexact;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        sign;
        logic [1:0]  cls;
        logic [9:0]  exp;
        logic [25:0] man;
        logic [31:0] res;
        logic [2:0]  flags; // {overflow, underflow, inexact}
    } vec_t;

    vec_t        vq[$];
    logic [31:0] exp_q[$];

    fp_round_pack dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .sign_in        (sign_in),
`ifdef FP_ROUND_MODES_EN
        .rnd_mode       (2'b00),
`endif
        .class_in       (class_in),
        .exponent_in    (exponent_in),
        .mantissa_in    (mantissa_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .flag_overflow  (flag_overflow),
        .flag_underflow (flag_underflow),
        .flag_inexact   (flag_inexact)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic add(input logic s, input logic [1:0] c, input logic [9:0] e,
                       input logic [25:0] m, input logic [31:0] r, input logic [2:0] f);
        vec_t v;
        v.sign = s; v.cls = c; v.exp = e; v.man = m; v.res = r; v.flags = f;
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        sign_in     = v.sign;
        class_in    = v.cls;
        exponent_in = v.exp;
        mantissa_in = v.man;
    endtask

    // Single transaction with no backpressure; checks latency, result and flags.
    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        @(negedge clk);
        drive(v);
        in_valid = 1'b1;
        #1;
        check($sformatf("vec%0d in_ready", idx), {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("vec%0d latency", idx), lat, 32'd2);
        check($sformatf("vec%0d result", idx), result, v.res);
        check($sformatf("vec%0d flags", idx),
              {29'h0, flag_overflow, flag_underflow, flag_inexact}, {29'h0, v.flags});
    endtask

    initial begin
        vec_t seq[4];
        int   sent;
        int   got;
        logic acc;
        logic drn;
        logic [31:0] held;

        arst_n      = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        sign_in     = 1'b0;
        class_in    = 2'b00;
        exponent_in = '0;
        mantissa_in = '0;
        held        = '0;

        // Vector table: sign, class, exponent, mantissa, result, {ovf,unf,inx}
        add(1'b0, 2'b00, 10'd127, {23'h000000, 3'b000}, 32'h3F800000, 3'b000);
        add(1'b0, 2'b00, 10'd127, {23'h000001, 3'b100}, 32'h3F800002, 3'b001);
        add(1'b0, 2'b00, 10'd127, {23'h000000, 3'b100}, 32'h3F800000, 3'b001);
        add(1'b0, 2'b00, 10'd127, {23'h7FFFFF, 3'b110}, 32'h40000000, 3'b001);
        add(1'b1, 2'b00, 10'd255, {23'h000000, 3'b000}, 32'hFF800000, 3'b101);
        add(1'b1, 2'b00, 10'h3FF, {23'h000000, 3'b000}, 32'h80000000, 3'b011);
        add(1'b1, 2'b11, 10'd127, {23'h123456, 3'b111}, 32'h7FC00000, 3'b000);
        add(1'b1, 2'b10, 10'd127, {23'h000000, 3'b000}, 32'hFF800000, 3'b000);
        add(1'b1, 2'b01, 10'd127, {23'h000000, 3'b000}, 32'h80000000, 3'b000);
        add(1'b0, 2'b00, 10'd254, {23'h7FFFFF, 3'b100}, 32'h7F800000, 3'b101);
        add(1'b0, 2'b00, 10'd0,   {23'h000000, 3'b000}, 32'h00000000, 3'b011);
        add(1'b0, 2'b00, 10'd1,   {23'h000000, 3'b000}, 32'h00800000, 3'b000);
        add(1'b0, 2'b00, 10'd254, {23'h7FFFFF, 3'b011}, 32'h7F7FFFFF, 3'b001);
        add(1'b0, 2'b00, 10'd127, {23'h000003, 3'b001}, 32'h3F800003, 3'b001);
        add(1'b0, 2'b00, 10'd127, {23'h000001, 3'b101}, 32'h3F800002, 3'b001);
        add(1'b1, 2'b00, 10'd200, {23'h123456, 3'b000}, 32'hE4123456, 3'b000);
        add(1'b0, 2'b00, 10'h200, {23'h000000, 3'b000}, 32'h00000000, 3'b011);
        add(1'b0, 2'b00, 10'h1FF, {23'h000000, 3'b000}, 32'h7F800000, 3'b101);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", {31'h0, out_valid}, 32'h0);
        check("reset result", result, 32'h0);
        check("reset flags", {29'h0, flag_overflow, flag_underflow, flag_inexact}, 32'h0);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset in_ready", {31'h0, in_ready}, 32'h1);

        for (int i = 0; i < vq.size(); i++) begin
            run_vec(i, vq[i]);
        end

        // Backpressure: four back-to-back inputs with out_ready low for 4 cycles
        repeat (2) @(posedge clk);
        seq[0] = vq[0];
        seq[1] = vq[1];
        seq[2] = vq[3];
        seq[3] = vq[4];
        sent = 0;
        got  = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (cyc >= 4) out_ready = 1'b1;
            in_valid = (sent < 4);
            if (sent < 4) drive(seq[sent]);
            #1;
            if (cyc == 2) held = result;
            if (cyc == 3) begin
                check("bp accepts before stall", sent, 32'd2);
                check("bp in_ready low", {31'h0, in_ready}, 32'h0);
                check("bp out_valid held", {31'h0, out_valid}, 32'h1);
                check("bp result stable", result, held);
                check("bp result first", result, seq[0].res);
            end
            acc = in_valid & in_ready;
            drn = out_valid & out_ready;
            if (drn) begin
                if (exp_q.size() == 0) begin
                    check("bp unexpected output", result, 32'hDEADBEEF);
                end else begin
                    check($sformatf("bp out%0d", got), result, exp_q.pop_front());
                end
                got++;
            end
            @(posedge clk);
            if (acc) begin
                exp_q.push_back(seq[sent].res);
                sent++;
            end
            if (got == 4 && sent == 4) break;
        end
        #1;
        in_valid = 1'b0;
        check("bp outputs drained", got, 32'd4);
        check("bp queue empty", exp_q.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("bp no duplicate", {31'h0, out_valid}, 32'h0);

        // Reset mid-stream discards in-flight data
        out_ready = 1'b0;
        @(negedge clk);
        drive(vq[1]);
        in_valid = 1'b1;
        @(negedge clk);
        drive(vq[3]);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("mid out_valid before reset", {31'h0, out_valid}, 32'h1);
        arst_n = 1'b0;
        #1;
        check("mid reset out_valid", {31'h0, out_valid}, 32'h0);
        check("mid reset result", result, 32'h0);
        check("mid reset flags", {29'h0, flag_overflow, flag_underflow, flag_inexact}, 32'h0);
        @(negedge clk);
        arst_n    = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("mid post-reset in_ready", {31'h0, in_ready}, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check("mid in-flight discarded", {31'h0, out_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_round_pack.md
Name: fp_round_pack

Overview:
- Final stage of the FP multiply/divide datapath. Sits directly downstream of the normaliser.
- Consumes the normalised 26-bit mantissa (23 fraction + 3 rounding bits), the unclamped 10-bit biased exponent and the result sign.
- Performs IEEE 754 rounding, exponent overflow/underflow handling and special-value packing.
- Emits a 32-bit single-precision word with exception flags through a 2-stage valid/ready pipeline.

Parameters:
- EXP_W, 10, width of incoming biased exponent (two's complement, bias 127)
- MAN_W, 26, width of incoming normalised mantissa (hidden bit already removed)

Ports:
- clk  input  1  clock, rising edge
- arst_n  input  1  asynchronous reset, active low
- in_valid  input  1  input operand valid
- in_ready  output  1  stage can accept input
- sign_in  input  1  result sign
- class_in  input  2  00 normal, 01 zero, 10 infinity, 11 NaN
- exponent_in  input  EXP_W  biased exponent, signed, not yet clamped
- mantissa_in  input  MAN_W  [25:3] fraction, [2] guard, [1] round, [0] sticky
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  32  packed IEEE single
- flag_overflow  output  1  result overflowed to infinity
- flag_underflow  output  1  result flushed to zero
- flag_inexact  output  1  rounding or flush discarded nonzero bits

Behaviour:
- Reset: clk is the only clock; arst_n is asynchronous, active-low. While arst_n = 0:
  - all pipeline valids clear;
  - out_valid = 0, result = 32'h0, all flags = 0;
  - in_ready = 1 from the first cycle after release.
- Reset mid-operation discards all in-flight data.
- Pipeline: S1 (round) and S2 (pack), each holding a valid bit.
  - Transfer occurs on valid & ready at a rising edge.
  - Latency is 2 cycles from input acceptance to out_valid, with no backpressure.
  - Throughput is 1 per cycle.
- Ready chain (combinational, no combinational path from in_valid to in_ready):
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv
- While out_valid = 1 and out_ready = 0, result and all flags hold stable.
- Simultaneous accept at the input and drain at the output in the same cycle is lossless.
- S1 rounding (RNE by default):
  - lsb = mantissa_in[3], g = [2], r = [1], s = [0].
  - inc = g & (r | s | lsb).
  - frac24 = {1'b0, fraction} + inc.
  - On carry (frac24[23] = 1): fraction = 0 and exponent + 1.
  - inexact_r = g | r | s.
  - Exponent arithmetic is EXP_W+1 bits signed, with no wrap.
- S2 packing, in priority order:
  1. NaN: 32'h7FC00000 (sign ignored); no flags.
  2. Infinity: {sign, 8'hFF, 23'h0}; no flags.
  3. Zero: {sign, 31'h0}; no flags.
  4. Rounded exponent >= 255: {sign, 8'hFF, 23'h0}; overflow = 1, inexact = 1.
  5. Rounded exponent <= 0: {sign, 31'h0}; underflow = 1, inexact = 1. Flush-to-zero; no subnormals.
  6. Otherwise: {sign, exp[7:0], fraction}; inexact = inexact_r.
- Flags are sampled together with result and are valid only when out_valid = 1. They are per-result, not sticky.

Optional Feature:
- Macro FP_ROUND_MODES_EN.
- Defined:
  - adds input rnd_mode [1:0]: 00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf), captured with the operand.
  - RTZ: inc = 0.
  - RUP: inc = !sign & (g|r|s).
  - RDN: inc = sign & (g|r|s).
  - Overflow under RTZ, or under RUP with a negative sign, or RDN with a positive sign, packs max finite {sign, 8'hFE, 23'h7FFFFF} with overflow = 1.
- Undefined: port absent; RNE only.

Decomposition:
- Package fp_pkg:
  - typedef fp_class_e (NORMAL, ZERO, INF, NAN);
  - typedef rnd_mode_e;
  - constants FP_BIAS = 127, FP_EXP_MAX = 255, FP_QNAN = 32'h7FC00000;
  - struct s1_payload_t (sign, class, exp, frac, inexact, mode).
- One sub-module, fp_rounder: combinational increment/carry/inexact logic, instantiated in S1.
- Pipeline control and packing stay in the top module.

Test Plan:
- exponent_in = 127, mantissa_in = 0, sign 0, class normal -> result 32'h3F800000 after 2 cycles, no flags.
- Fraction 23'h000001, GRS = 100, exp 127 -> tie rounds to even, fraction 23'h000002 -> 32'h3F800002, inexact = 1. The same with fraction 0 gives 32'h3F800000, inexact = 1.
- Fraction 23'h7FFFFF, GRS = 110, exp 127 -> carry, result 32'h40000000, inexact = 1.
- exponent_in = 255, sign 1 -> 32'hFF800000, overflow = 1, inexact = 1. exponent_in = 10'h3FF (-1), sign 1 -> 32'h80000000, underflow = 1.
- class NaN / infinity (sign 1) / zero (sign 1) -> 32'h7FC00000 / 32'hFF800000 / 32'h80000000, no flags.
- Four back-to-back inputs with out_ready = 0 for 4 cycles:
  - in_ready drops after 2 accepts;
  - result holds stable;
  - after out_ready rises, all 4 results emerge in order with no loss or duplication.
  - Assert arst_n mid-stream -> out_valid = 0 immediately.
